xdma_to_remote_arbiter: RTL and testbench
=========================================

Name: xdma_to_remote_arbiter

Overview:
- Shares the single outbound AXI write path of the XDMA between the four to-remote sources: Finish, Grant, Cfg and Data (xdma_to_remote_idx_e order).
- Picks one source at a time and emits one AW descriptor (xdma_req_aw_desc_t) plus the matching W descriptor (xdma_req_w_desc_t).
- Streams that source's beats to the W channel until the last beat, then re-arbitrates.
- Sits between the XDMA frontend/datapath and the AXI master adapter.

Parameters:
- NumInp, 4 (NUM_INP): number of requesters; index 0 is highest priority.
- BeatSize, 3'd6: AXI size field; 64 B beats for AxiDataWidth=512.
- CacheAttr, 4'b0010: AXI cache field for every AW.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- inp_valid_i  in  NumInp  per-source beat valid
- inp_ready_o  out  NumInp  per-source beat accepted
- inp_data_i  in  NumInp x 512  per-source beat payload (data_t)
- inp_addr_i  in  NumInp x 48  per-source remote destination address (addr_t)
- inp_id_i  in  NumInp x 8  per-source dma_id (id_t)
- inp_len_i  in  NumInp x 8  per-source beats minus one; forced to 0 for idx != ToRemoteData
- aw_desc_o  out  $bits(xdma_req_aw_desc_t)  AW descriptor
- aw_valid_o  out  1  AW descriptor valid
- aw_ready_i  in  1  AW descriptor accepted
- w_desc_o  out  $bits(xdma_req_w_desc_t)  W descriptor; valid together with aw_valid_o
- w_data_o  out  512  beat data
- w_strb_o  out  64  all ones
- w_last_o  out  1  final beat of the burst
- w_valid_o  out  1  beat valid
- w_ready_i  in  1  beat accepted
- busy_o  out  1  state != IDLE
- cur_idx_o  out  2  locked source (xdma_req_idx_t)

Behaviour:
- Reset values (async, rst_ni low): state=IDLE; all valids, inp_ready_o, w_last_o and busy_o are 0; aw_desc_o, w_desc_o, cur_idx_o and beat_cnt are 0.
- Reset mid-burst aborts immediately. No w_last is emitted, and the upstream is responsible for flushing.
- FSM states: IDLE, AW, W.
- IDLE:
  - If any inp_valid_i is set, pick the lowest set index (fixed priority: Finish > Grant > Cfg > Data).
  - Register idx, id, addr and len into aw_desc_o/w_desc_o and go to AW; aw_valid_o=1 the next cycle.
  - Latency from the request cycle to aw_valid_o is 1 cycle.
  - inp_ready_o=0 in IDLE; a valid is not consumed during arbitration.
- AW:
  - Hold aw_valid_o and both descriptors stable until aw_ready_i.
  - On handshake: go to W, beat_cnt=0.
  - Descriptor fields:
    - aw.len = w.num_beats = latched len.
    - aw.size = BeatSize; aw.burst = 2'b01 (INCR); aw.cache = CacheAttr.
    - is_write_data = (idx == ToRemoteData).
    - w.is_single = (len == 0).
- W:
  - Pass-through: w_valid_o = inp_valid_i[idx]; inp_ready_o[idx] = w_ready_i; w_data_o = inp_data_i[idx]. The other inp_ready_o bits are 0.
  - w_last_o = (beat_cnt == len), combinational.
  - beat_cnt increments on each w handshake.
  - On the handshake with w_last_o set: go to IDLE. There is one IDLE bubble cycle before the next arbitration.
  - beat_cnt is 8 bits; len=255 gives 256 beats with no wrap before last.
- Lock: no preemption. A higher-priority request arriving during AW or W waits until return to IDLE.
- Valid-drop: the source deasserting valid in W stalls the W channel (w_valid_o=0) and keeps the lock.
- AW and W are strictly sequential: w_valid_o is never 1 before the AW handshake of the same burst.
- Starvation of Data under continuous control traffic is accepted. Control messages are single-beat and rare by protocol.

Decomposition:
- Shared package (xdma_pkg): xdma_to_remote_idx_e, xdma_req_idx_t, xdma_req_aw_desc_t, xdma_req_w_desc_t, addr_t, id_t, data_t, strb_t.
- New package constants: AxiBurstIncr=2'b01 and the default cache value.
- One natural sub-module, xdma_fixed_prio_arbiter: a combinational lowest-index-first picker returning an onehot grant and an index. It is instantiated once; the FSM, descriptor registers and beat counter stay in the top.

Test Plan:
- Single Grant request (idx1, addr 0x1000_0000, id 5) -> aw_valid one cycle later: addr 0x1000_0000, len 0, is_write_data 0, w.is_single 1. Then one W beat with w_last=1, then IDLE.
- Finish, Cfg and Data valid in the same cycle -> bursts are served in order Finish, Cfg, Data. Each AW precedes its W, with one IDLE bubble between bursts.
- Data burst, len=3, w_ready toggling 1/0 -> exactly 4 beats forwarded in order, w_last only on the 4th, is_write_data=1, aw.len=3.
- Data burst, len=255 -> 256 beats and w_last on beat 256. A Grant arriving mid-burst is served only after that beat.
- aw_ready held low 10 cycles -> aw_desc_o stable, no W beats, inp_ready_o all 0.
- rst_ni asserted at beat 2 of a len=7 burst -> all outputs 0 asynchronously. After release, a new Finish request is granted normally.

Source files
------------

// File: rtl/xdma_pkg.sv
// Shared XDMA types for the to-remote write path: source indices, AXI descriptor
// structs and the AXI constants used by the outbound arbiter.
package xdma_pkg;

    localparam int unsigned NumInp = 4;

    localparam logic [2:0] BeatSize     = 3'd6;
    localparam logic [1:0] AxiBurstIncr = 2'b01;
    localparam logic [3:0] CacheAttr    = 4'b0010;

    typedef logic [47:0]  addr_t;
    typedef logic [7:0]   id_t;
    typedef logic [7:0]   len_t;
    typedef logic [511:0] data_t;
    typedef logic [63:0]  strb_t;

    typedef enum logic [1:0] {
        ToRemoteFinish = 2'd0,
        ToRemoteGrant  = 2'd1,
        ToRemoteCfg    = 2'd2,
        ToRemoteData   = 2'd3
    } xdma_to_remote_idx_e;

    typedef logic [1:0] xdma_req_idx_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        len_t       len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [3:0] cache;
        logic       is_write_data;
    } xdma_req_aw_desc_t;

    typedef struct packed {
        xdma_req_idx_t idx;
        len_t          num_beats;
        logic          is_single;
    } xdma_req_w_desc_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAw   = 2'd1,
        StW    = 2'd2
    } arb_state_e;

endpackage

// File: rtl/xdma_fixed_prio_arbiter.sv
// Combinational fixed-priority picker: the lowest set request index wins,
// reported both as a onehot grant and as a binary index.
module xdma_fixed_prio_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    // NOTE: every output gets a default before the loop so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/xdma_to_remote_arbiter.sv
// Shares the XDMA outbound AXI write path between the four to-remote sources:
// lock one source, issue its AW + W descriptors, stream its beats, re-arbitrate.
module xdma_to_remote_arbiter
    import xdma_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumInp-1:0]            inp_valid_i,
    output logic [NumInp-1:0]            inp_ready_o,
    input  data_t [NumInp-1:0]           inp_data_i,
    input  addr_t [NumInp-1:0]           inp_addr_i,
    input  id_t [NumInp-1:0]             inp_id_i,
    input  len_t [NumInp-1:0]            inp_len_i,
    output xdma_req_aw_desc_t            aw_desc_o,
    output logic                         aw_valid_o,
    input  logic                         aw_ready_i,
    output xdma_req_w_desc_t             w_desc_o,
    output data_t                        w_data_o,
    output strb_t                        w_strb_o,
    output logic                         w_last_o,
    output logic                         w_valid_o,
    input  logic                         w_ready_i,
    output logic                         busy_o,
    output xdma_req_idx_t                cur_idx_o
);

    arb_state_e        state_q, state_d;
    xdma_req_idx_t     idx_q, idx_d;
    xdma_req_aw_desc_t aw_desc_q, aw_desc_d;
    xdma_req_w_desc_t  w_desc_q, w_desc_d;
    len_t              beat_cnt_q, beat_cnt_d;
    len_t              sel_len;

    logic [NumInp-1:0] arb_gnt;
    xdma_req_idx_t     arb_idx;
    logic              arb_valid;

    xdma_fixed_prio_arbiter #(.N(NumInp)) i_prio_arb (
        .req_i   (inp_valid_i),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        aw_desc_d   = aw_desc_q;
        w_desc_d    = w_desc_q;
        beat_cnt_d  = beat_cnt_q;
        sel_len     = '0;
        aw_valid_o  = 1'b0;
        w_valid_o   = 1'b0;
        w_last_o    = 1'b0;
        inp_ready_o = '0;

        unique case (state_q)
            StIdle: begin
                // Control messages are single-beat, so only Data may carry a length.
                if (arb_valid) begin
                    sel_len   = arb_gnt[ToRemoteData] ? inp_len_i[arb_idx] : '0;
                    idx_d     = arb_idx;
                    aw_desc_d = '{id:            inp_id_i[arb_idx],
                                  addr:          inp_addr_i[arb_idx],
                                  len:           sel_len,
                                  size:          BeatSize,
                                  burst:         AxiBurstIncr,
                                  cache:         CacheAttr,
                                  is_write_data: arb_gnt[ToRemoteData]};
                    w_desc_d  = '{idx:       arb_idx,
                                  num_beats: sel_len,
                                  is_single: (sel_len == '0)};
                    state_d   = StAw;
                end
            end
            StAw: begin
                aw_valid_o = 1'b1;
                if (aw_ready_i) begin
                    beat_cnt_d = '0;
                    state_d    = StW;
                end
            end
            StW: begin
                w_valid_o          = inp_valid_i[idx_q];
                inp_ready_o[idx_q] = w_ready_i;
                w_last_o           = (beat_cnt_q == w_desc_q.num_beats);
                if (w_valid_o && w_ready_i) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (w_last_o) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            aw_desc_q  <= '0;
            w_desc_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            aw_desc_q  <= aw_desc_d;
            w_desc_q   <= w_desc_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign aw_desc_o = aw_desc_q;
    assign w_desc_o  = w_desc_q;
    assign w_data_o  = inp_data_i[idx_q];
    assign w_strb_o  = '1;
    assign busy_o    = (state_q != StIdle);
    assign cur_idx_o = idx_q;

endmodule

// File: tb/tb_xdma_to_remote_arbiter.sv
// Self-checking bench for xdma_to_remote_arbiter: arbitration vector table plus
// scoreboarded burst sequences (ordering, stalls, long bursts, mid-burst reset).
module tb_xdma_to_remote_arbiter;
    import xdma_pkg::*;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [3:0]        inp_valid_i;
    logic [3:0]        inp_ready_o;
    data_t [3:0]       inp_data_i;
    addr_t [3:0]       inp_addr_i;
    id_t [3:0]         inp_id_i;
    len_t [3:0]        inp_len_i;
    xdma_req_aw_desc_t aw_desc_o;
    logic              aw_valid_o;
    logic              aw_ready_i;
    xdma_req_w_desc_t  w_desc_o;
    data_t             w_data_o;
    strb_t             w_strb_o;
    logic              w_last_o;
    logic              w_valid_o;
    logic              w_ready_i;
    logic              busy_o;
    xdma_req_idx_t     cur_idx_o;

    xdma_to_remote_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .inp_valid_i (inp_valid_i),
        .inp_ready_o (inp_ready_o),
        .inp_data_i  (inp_data_i),
        .inp_addr_i  (inp_addr_i),
        .inp_id_i    (inp_id_i),
        .inp_len_i   (inp_len_i),
        .aw_desc_o   (aw_desc_o),
        .aw_valid_o  (aw_valid_o),
        .aw_ready_i  (aw_ready_i),
        .w_desc_o    (w_desc_o),
        .w_data_o    (w_data_o),
        .w_strb_o    (w_strb_o),
        .w_last_o    (w_last_o),
        .w_valid_o   (w_valid_o),
        .w_ready_i   (w_ready_i),
        .busy_o      (busy_o),
        .cur_idx_o   (cur_idx_o)
    );

    always #5 clk = ~clk;

    // Per-source driver state
    logic  vld  [4];
    data_t dat  [4];
    addr_t adr  [4];
    id_t   idv  [4];
    len_t  lenv [4];

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            inp_valid_i[s] = vld[s];
            inp_data_i[s]  = dat[s];
            inp_addr_i[s]  = adr[s];
            inp_id_i[s]    = idv[s];
            inp_len_i[s]   = lenv[s];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard
    typedef struct {
        xdma_req_aw_desc_t aw;
        xdma_req_w_desc_t  w;
    } exp_aw_t;

    typedef struct {
        data_t         data;
        logic          last;
        xdma_req_idx_t idx;
    } exp_w_t;

    exp_aw_t exp_aw_q [$];
    exp_w_t  exp_w_q  [$];

    function automatic data_t beat_data(input int s, input id_t i, input int b);
        return {16{8'(s), i, 16'(b)}};
    endfunction

    task automatic push_exp(input int s, input addr_t a, input id_t i, input len_t l);
        exp_aw_t ea;
        exp_w_t  ew;
        len_t    eff;
        eff = (s == 3) ? l : 8'd0;
        ea.aw.id            = i;
        ea.aw.addr          = a;
        ea.aw.len           = eff;
        ea.aw.size          = 3'd6;
        ea.aw.burst         = 2'b01;
        ea.aw.cache         = 4'b0010;
        ea.aw.is_write_data = (s == 3);
        ea.w.idx            = 2'(s);
        ea.w.num_beats      = eff;
        ea.w.is_single      = (eff == 8'd0);
        exp_aw_q.push_back(ea);
        for (int b = 0; b <= int'(eff); b++) begin
            ew.data = beat_data(s, i, b);
            ew.last = (b == int'(eff));
            ew.idx  = 2'(s);
            exp_w_q.push_back(ew);
        end
    endtask

    task automatic mon_aw();
        exp_aw_t ea;
        check("aw_q_nonempty", exp_aw_q.size() != 0, 1'b1);
        if (exp_aw_q.size() != 0) begin
            ea = exp_aw_q.pop_front();
            check("aw_desc", aw_desc_o, ea.aw);
            check("w_desc", w_desc_o, ea.w);
        end
        check("w_before_aw", w_valid_o, 1'b0);
    endtask

    task automatic mon_w();
        exp_w_t ew;
        check("w_q_nonempty", exp_w_q.size() != 0, 1'b1);
        if (exp_w_q.size() != 0) begin
            ew = exp_w_q.pop_front();
            check("w_data", w_data_o, ew.data);
            check("w_last", w_last_o, ew.last);
            check("w_idx", cur_idx_o, ew.idx);
        end
        check("w_strb", w_strb_o, {64{1'b1}});
    endtask

    int   w_hs_cnt   = 0;
    logic bubble_chk = 1'b0;

    always @(negedge clk) begin
        if (!rst_ni) begin
            bubble_chk <= 1'b0;
        end else begin
            if (bubble_chk) begin
                check("bubble_busy", busy_o, 1'b0);
                check("bubble_aw_valid", aw_valid_o, 1'b0);
            end
            bubble_chk <= w_valid_o && w_ready_i && w_last_o;
            if (aw_valid_o && aw_ready_i) mon_aw();
            if (w_valid_o && w_ready_i) begin
                mon_w();
                w_hs_cnt <= w_hs_cnt + 1;
            end
        end
    end

    // Drives one burst from source s; returns early if reset hits mid-burst.
    task automatic src_send(input int s, input addr_t a, input id_t i, input len_t l);
        logic hs;
        len_t eff;
        eff     = (s == 3) ? l : 8'd0;
        adr[s]  = a;
        idv[s]  = i;
        lenv[s] = l;
        for (int b = 0; b <= int'(eff); b++) begin
            dat[s] = beat_data(s, i, b);
            vld[s] = 1'b1;
            hs     = 1'b0;
            for (int c = 0; c < 4000 && !hs; c++) begin
                @(negedge clk);
                if (!rst_ni) begin
                    vld[s] = 1'b0;
                    return;
                end
                hs = inp_ready_o[s];
            end
            @(posedge clk);
            #1;
            check("src_handshake", hs, 1'b1);
            if (!hs) begin
                vld[s] = 1'b0;
                return;
            end
        end
        vld[s] = 1'b0;
    endtask

    task automatic drain(input string n);
        int c;
        c = 0;
        while ((exp_aw_q.size() != 0 || exp_w_q.size() != 0) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({n, "_aw_left"}, exp_aw_q.size(), 0);
        check({n, "_w_left"}, exp_w_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic addr_t tbl_addr(input int s);
        return 48'h1000_0000 + (48'(s) << 8);
    endfunction

    typedef struct {
        logic [3:0]    mask;
        logic          exp_aw_valid;
        xdma_req_idx_t exp_idx;
        len_t          exp_len;
        logic          exp_wd;
    } vec_t;

    vec_t vecs [7];
    logic tog_done;

    initial begin
        xdma_req_aw_desc_t hold_desc;

        vecs[0] = '{mask: 4'b0010, exp_aw_valid: 1'b1, exp_idx: 2'd1, exp_len: 8'd0, exp_wd: 1'b0};
        vecs[1] = '{mask: 4'b1000, exp_aw_valid: 1'b1, exp_idx: 2'd3, exp_len: 8'd5, exp_wd: 1'b1};
        vecs[2] = '{mask: 4'b1100, exp_aw_valid: 1'b1, exp_idx: 2'd2, exp_len: 8'd0, exp_wd: 1'b0};
        vecs[3] = '{mask: 4'b1111, exp_aw_valid: 1'b1, exp_idx: 2'd0, exp_len: 8'd0, exp_wd: 1'b0};
        vecs[4] = '{mask: 4'b1010, exp_aw_valid: 1'b1, exp_idx: 2'd1, exp_len: 8'd0, exp_wd: 1'b0};
        vecs[5] = '{mask: 4'b0101, exp_aw_valid: 1'b1, exp_idx: 2'd0, exp_len: 8'd0, exp_wd: 1'b0};
        vecs[6] = '{mask: 4'b0000, exp_aw_valid: 1'b0, exp_idx: 2'd0, exp_len: 8'd0, exp_wd: 1'b0};

        rst_ni     = 1'b0;
        aw_ready_i = 1'b0;
        w_ready_i  = 1'b0;
        tog_done   = 1'b0;
        for (int s = 0; s < 4; s++) begin
            vld[s] = 1'b0; dat[s] = '0; adr[s] = '0; idv[s] = '0; lenv[s] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_aw_valid", aw_valid_o, 1'b0);
        check("rst_w_valid", w_valid_o, 1'b0);
        check("rst_w_last", w_last_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_inp_ready", inp_ready_o, 4'b0);
        check("rst_cur_idx", cur_idx_o, 2'd0);
        check("rst_aw_desc", aw_desc_o, '0);
        check("rst_w_desc", w_desc_o, '0);

        // Arbitration table: request cycle, then the AW cycle one clock later
        foreach (vecs[r]) begin
            @(posedge clk);
            #1;
            rst_ni = 1'b0;
            for (int s = 0; s < 4; s++) begin
                vld[s]  = vecs[r].mask[s];
                adr[s]  = tbl_addr(s);
                idv[s]  = 8'(s + 16);
                lenv[s] = 8'd5;
            end
            #1;
            rst_ni = 1'b1;
            @(negedge clk);
            check("tbl_req_aw_valid", aw_valid_o, 1'b0);
            check("tbl_req_inp_ready", inp_ready_o, 4'b0);
            @(negedge clk);
            check("tbl_aw_valid", aw_valid_o, vecs[r].exp_aw_valid);
            check("tbl_cur_idx", cur_idx_o, vecs[r].exp_idx);
            check("tbl_aw_len", aw_desc_o.len, vecs[r].exp_len);
            check("tbl_is_write_data", aw_desc_o.is_write_data, vecs[r].exp_wd);
            check("tbl_aw_addr", aw_desc_o.addr,
                  vecs[r].exp_aw_valid ? tbl_addr(int'(vecs[r].exp_idx)) : 48'd0);
            for (int s = 0; s < 4; s++) vld[s] = 1'b0;
        end

        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        for (int s = 0; s < 4; s++) lenv[s] = '0;
        #1;
        rst_ni     = 1'b1;
        aw_ready_i = 1'b1;
        w_ready_i  = 1'b1;

        // Single Grant request
        push_exp(1, 48'h1000_0000, 8'd5, 8'd0);
        src_send(1, 48'h1000_0000, 8'd5, 8'd0);
        drain("grant");
        check("grant_idle_busy", busy_o, 1'b0);

        // Finish, Cfg and Data together: served in priority order
        push_exp(0, 48'h0000_0100, 8'd1, 8'd0);
        push_exp(2, 48'h0000_0200, 8'd2, 8'd0);
        push_exp(3, 48'h0000_0300, 8'd3, 8'd2);
        fork
            src_send(0, 48'h0000_0100, 8'd1, 8'd0);
            src_send(2, 48'h0000_0200, 8'd2, 8'd0);
            src_send(3, 48'h0000_0300, 8'd3, 8'd2);
        join
        drain("prio");

        // Data len=3 with w_ready toggling
        push_exp(3, 48'h2000_0000, 8'd7, 8'd3);
        tog_done = 1'b0;
        fork
            begin
                src_send(3, 48'h2000_0000, 8'd7, 8'd3);
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin
                    @(posedge clk);
                    #1;
                    w_ready_i = ~w_ready_i;
                end
            end
        join
        w_ready_i = 1'b1;
        drain("toggle");

        // Data len=255 with a Grant arriving mid-burst
        push_exp(3, 48'h3000_0000, 8'd9, 8'd255);
        push_exp(1, 48'h3100_0000, 8'd10, 8'd0);
        fork
            src_send(3, 48'h3000_0000, 8'd9, 8'd255);
            begin
                repeat (60) @(posedge clk);
                #1;
                src_send(1, 48'h3100_0000, 8'd10, 8'd0);
            end
        join
        drain("long");

        // aw_ready held low for 10 cycles
        aw_ready_i = 1'b0;
        hold_desc  = '{id: 8'd11, addr: 48'h4000_0000, len: 8'd0, size: 3'd6,
                       burst: 2'b01, cache: 4'b0010, is_write_data: 1'b0};
        push_exp(0, 48'h4000_0000, 8'd11, 8'd0);
        fork
            src_send(0, 48'h4000_0000, 8'd11, 8'd0);
            begin
                @(negedge clk);
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("awhold_valid", aw_valid_o, 1'b1);
                    check("awhold_desc", aw_desc_o, hold_desc);
                    check("awhold_w_valid", w_valid_o, 1'b0);
                    check("awhold_inp_ready", inp_ready_o, 4'b0);
                end
                @(posedge clk);
                #1;
                aw_ready_i = 1'b1;
            end
        join
        drain("awhold");

        // Reset during beat 2 of a len=7 Data burst
        push_exp(3, 48'h5000_0000, 8'd12, 8'd7);
        fork
            src_send(3, 48'h5000_0000, 8'd12, 8'd7);
            begin
                int base;
                int c;
                base = w_hs_cnt;
                c    = 0;
                while (w_hs_cnt < base + 2 && c < 200) begin
                    @(posedge clk);
                    c++;
                end
                check("midrst_reached_beat2", w_hs_cnt >= base + 2, 1'b1);
                #3;
                rst_ni = 1'b0;
                #1;
                check("midrst_aw_valid", aw_valid_o, 1'b0);
                check("midrst_w_valid", w_valid_o, 1'b0);
                check("midrst_w_last", w_last_o, 1'b0);
                check("midrst_busy", busy_o, 1'b0);
                check("midrst_inp_ready", inp_ready_o, 4'b0);
                check("midrst_cur_idx", cur_idx_o, 2'd0);
                check("midrst_aw_desc", aw_desc_o, '0);
                check("midrst_w_desc", w_desc_o, '0);
                exp_aw_q.delete();
                exp_w_q.delete();
                repeat (2) @(posedge clk);
                #1;
                rst_ni = 1'b1;
            end
        join
        push_exp(0, 48'h6000_0000, 8'd13, 8'd0);
        src_send(0, 48'h6000_0000, 8'd13, 8'd0);
        drain("postrst");
        check("postrst_busy", busy_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
